// File: rtl/fp_pkg.sv
// Shared floating-point types and format helpers for the FP datapath.
// Result width follows fp_format_e. Unrounded results carry a round bit and a
// sticky bit next to the truncated value.
package fp_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        BF16 = 2'd2
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    // IEEE exception flags, packed MSB..LSB as {NV,DZ,OF,UF,NX}
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    localparam int unsigned FP_MAX_WIDTH = 32;

    // Truncated result (right-aligned for narrower formats) plus {round, sticky}
    typedef struct packed {
        logic [FP_MAX_WIDTH-1:0] value;
        logic [1:0]              rs;
    } uround_res_t;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP16:    return 16;
            BF16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

endpackage

// File: rtl/fp_rnd.sv
// Rounding unit: applies the rounding mode to a truncated FP value using its
// round/sticky bits, handles overflow to inf or max-finite, and passes
// inf/NaN through (signalling NaNs are quieted and raise NV).
module fp_rnd
    import fp_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23
) (
    input  logic [EXP_WIDTH+MANT_WIDTH:0] value_i,
    input  logic [1:0]                    rs_i,
    input  roundmode_e                    rnd_mode_i,
    input  logic                          round_only_i,
    input  logic                          mul_ovf_i,
    output logic [EXP_WIDTH+MANT_WIDTH:0] result_o,
    output status_t                       status_o
);

    localparam int unsigned W = EXP_WIDTH + MANT_WIDTH + 1;

    logic                  sign;
    logic [W-2:0]          mag;
    logic [W-2:0]          mag_rnd;
    logic [EXP_WIDTH-1:0]  exp_in;
    logic [EXP_WIDTH-1:0]  exp_rnd;
    logic [MANT_WIDTH-1:0] man_in;
    logic                  inexact;
    logic                  round_up;
    logic                  special;
    logic                  is_snan;
    logic                  ovf;
    logic                  to_inf;

    // Round the magnitude, then resolve special operands and overflow/underflow
    always_comb begin
        sign     = value_i[W-1];
        mag      = value_i[W-2:0];
        exp_in   = mag[W-2:MANT_WIDTH];
        man_in   = mag[MANT_WIDTH-1:0];
        special  = &exp_in;
        is_snan  = special & (|man_in) & ~man_in[MANT_WIDTH-1];
        inexact  = |rs_i;
        round_up = 1'b0;
        to_inf   = 1'b0;
        case (rnd_mode_i)
            RNE: begin
                round_up = rs_i[1] & (rs_i[0] | mag[0]);
                to_inf   = 1'b1;
            end
            RTZ: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
            RDN: begin
                round_up = inexact & sign;
                to_inf   = sign;
            end
            RUP: begin
                round_up = inexact & ~sign;
                to_inf   = ~sign;
            end
            RMM: begin
                round_up = rs_i[1];
                to_inf   = 1'b1;
            end
            default: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
        endcase
        // A mantissa carry ripples into the exponent, which is the correct renormalisation
        mag_rnd  = mag + {{(W-2){1'b0}}, round_up};
        exp_rnd  = mag_rnd[W-2:MANT_WIDTH];
        ovf      = ~special & ((&exp_rnd) | mul_ovf_i);
        status_o = '0;
        result_o = {sign, mag_rnd};
        if (special) begin
            result_o = value_i;
            if (is_snan) begin
                result_o[MANT_WIDTH-1] = 1'b1;
                status_o.nv            = 1'b1;
            end
        end else begin
            status_o.nx = inexact;
            if (ovf) begin
                status_o.nx = 1'b1;
                status_o.of = ~round_only_i;
                result_o    = to_inf ? {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}}
                                     : {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
            end else begin
                status_o.uf = inexact & ~round_only_i & (exp_rnd == '0);
            end
        end
    end

endmodule

// File: rtl/fp_result_stage.sv
// Result/writeback stage behind the iterative FP units: one input register
// (S1) feeding fp_rnd, then an in-order FIFO toward register-file writeback.
// Optional feature macro FP_RES_FLAG_ACC_EN adds sticky accumulated flags
// (acc_flags_o) updated on every pop, cleared by acc_clr_i.
module fp_result_stage
    import fp_pkg::*;
#(
    parameter fp_format_e  FP_FORMAT = FP32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  uround_res_t                     urnd_i,
    input  roundmode_e                      rnd_i,
    input  logic                            dz_i,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    input  logic                            flush_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [fp_width(FP_FORMAT)-1:0]  result_o,
    output status_t                         flags_o,
`ifdef FP_RES_FLAG_ACC_EN
    output status_t                         acc_flags_o,
    input  logic                            acc_clr_i,
`endif
    output logic [TAG_WIDTH-1:0]            tag_o
);

    localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT);
    localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT);
    localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT);
    localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

    // FIFO entry kept local because its widths depend on this instance's parameters
    typedef struct packed {
        logic [FP_WIDTH-1:0]  result;
        status_t              flags;
        logic [TAG_WIDTH-1:0] tag;
    } res_entry_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    uround_res_t          s1_urnd_q,  s1_urnd_d;
    roundmode_e           s1_rnd_q,   s1_rnd_d;
    logic                 s1_dz_q,    s1_dz_d;
    logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;

    res_entry_t           fifo_q [DEPTH];
    res_entry_t           fifo_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;

    logic [FP_WIDTH-1:0]  rnd_result;
    status_t              rnd_status;
    res_entry_t           new_entry;
    res_entry_t           head;
    logic                 pop;
    logic                 space;
    logic                 push;
    logic                 accept;

    fp_rnd #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_fp_rnd (
        .value_i      (s1_urnd_q.value[FP_WIDTH-1:0]),
        .rs_i         (s1_urnd_q.rs),
        .rnd_mode_i   (s1_rnd_q),
        .round_only_i (1'b0),
        .mul_ovf_i    (1'b0),
        .result_o     (rnd_result),
        .status_o     (rnd_status)
    );

    // Handshake decode; a pop in the same cycle frees the slot for S1
    always_comb begin
        head        = fifo_q[rd_ptr_q];
        out_valid_o = (count_q != '0);
        pop         = out_valid_o & out_ready_i;
        space       = (count_q != CNT_W'(DEPTH)) | pop;
        push        = s1_valid_q & space;
        in_ready_o  = ~s1_valid_q | space;
        accept      = in_valid_i & in_ready_o;
        result_o    = out_valid_o ? head.result : '0;
        flags_o     = out_valid_o ? head.flags  : '0;
        tag_o       = out_valid_o ? head.tag    : '0;
    end

    // Next state for S1 and the FIFO; flush overrides push, pop and capture
    always_comb begin
        new_entry        = '0;
        new_entry.result = rnd_result;
        new_entry.flags  = rnd_status;
        new_entry.flags.dz = s1_dz_q | rnd_status.dz;
        new_entry.tag    = s1_tag_q;

        s1_valid_d = s1_valid_q;
        s1_urnd_d  = s1_urnd_q;
        s1_rnd_d   = s1_rnd_q;
        s1_dz_d    = s1_dz_q;
        s1_tag_d   = s1_tag_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_urnd_d  = urnd_i;
            s1_rnd_d   = rnd_i;
            s1_dz_d    = dz_i;
            s1_tag_d   = tag_i;
        end else if (push) begin
            s1_valid_d = 1'b0;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push & ~pop) begin
            count_d = count_q + 1'b1;
        end else if (pop & ~push) begin
            count_d = count_q - 1'b1;
        end

        if (flush_i) begin
            s1_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_urnd_q  <= '0;
            s1_rnd_q   <= RNE;
            s1_dz_q    <= 1'b0;
            s1_tag_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_urnd_q  <= s1_urnd_d;
            s1_rnd_q   <= s1_rnd_d;
            s1_dz_q    <= s1_dz_d;
            s1_tag_q   <= s1_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end

`ifdef FP_RES_FLAG_ACC_EN
    status_t acc_flags_q, acc_flags_d;

    // Sticky flag accumulation; a clear coinciding with a pop keeps only the popped flags
    always_comb begin
        acc_flags_d = acc_clr_i ? status_t'('0) : acc_flags_q;
        if (pop) begin
            acc_flags_d = acc_flags_d | head.flags;
        end
    end

    // Accumulated flag register, unaffected by flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_flags_q <= '0;
        end else begin
            acc_flags_q <= acc_flags_d;
        end
    end

    assign acc_flags_o = acc_flags_q;
`endif

endmodule
